porownanie_bist: RTL and testbench
==================================

# porownanie_bist

Built-in self-test driver and checker for the combinational comparator of the arithmetic unit. It is the active end of the comparator interface: it generates pseudo-random operand pairs, drives them onto the comparator inputs, reads back the comparator result and checks it against an internally computed expectation. It counts mismatches and reports pass/fail, replacing the simulation-only random stimulus with a synthesizable, on-chip equivalent.

## Interface
- BITS, 32, operand width; legal range 1..32
- N_VECTORS, 16, operand pairs per run; ≥1
- SEED, 32'h0000_0001, xorshift32 seed; must be nonzero
- CW, $clog2(N_VECTORS+1), derived width of the counters
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  start a run; single-cycle pulse or level
- o_arg_A  out  BITS  operand A to the comparator
- o_arg_B  out  BITS  operand B to the comparator
- i_result  in  1  comparator o_result, combinational from o_arg_A/o_arg_B
- o_busy  out  1  run in progress
- o_done  out  1  run finished; held until the next start or reset
- o_pass  out  1  valid when o_done=1; 1 when o_err_cnt==0
- o_err_cnt  out  CW  mismatch count, saturating at 2^CW-1
- o_vec_cnt  out  CW  number of vectors checked in the current or last run

## Operation
- Generator: 32-bit xorshift32. One step is x^=x<<13; x^=x>>17; x^=x<<5.
- Each vector takes two steps: s1=step(s), s2=step(s1). Then o_arg_A=s1[BITS-1:0], o_arg_B=s2[BITS-1:0], and s←s2.
- The generator state is loaded with SEED on every accepted start, so runs are reproducible.
- Expected result: 1 when o_arg_A > o_arg_B (unsigned), else 0. This is the comparator's contract.
- States:
  - IDLE: o_busy=0. i_start=1 goes to GEN and clears o_err_cnt, o_vec_cnt and o_done.
  - GEN: register the new operand pair; go to CHECK.
  - CHECK: operands are stable for the whole cycle. At the edge ending CHECK, sample i_result, compare it with the expectation, and increment o_err_cnt on mismatch. o_vec_cnt increments every CHECK. If o_vec_cnt+1==N_VECTORS go to DONE, else go to GEN.
  - DONE: o_done=1, o_busy=0, o_pass=(o_err_cnt==0). i_start=1 starts a new run, same as from IDLE.
- i_start is ignored in GEN and CHECK.
- o_arg_A and o_arg_B hold their last values in DONE.

## Timing
- Reset value of every output is 0, including o_arg_A, o_arg_B and o_pass. The state is IDLE and the generator holds SEED.
- Reset asserted mid-run clears everything immediately (asynchronously) and aborts the run. No o_done is produced.
- Start accepted at edge 0: o_busy=1 from edge 0. The first operands are visible after edge 1 (GEN).
- Vector k: operands appear at edge 2k+1 and are sampled at edge 2k+2. Cost is 2 cycles per vector.
- o_done rises at edge 2·N_VECTORS; o_busy falls on the same edge.
- A mismatch on the last vector is already included in o_err_cnt when o_done rises.
- Wrap-around: o_err_cnt saturates and never wraps; o_vec_cnt is at most N_VECTORS.

## Configuration
- PORWN_BIST_CAPTURE_EN defined: adds o_fail_A[BITS], o_fail_B[BITS] and o_fail_idx[CW].
  - These capture the operands and vector index of the first mismatch of a run.
  - They are cleared to 0 on reset and on start, and are frozen after the first capture.
- PORWN_BIST_CAPTURE_EN undefined: these ports and registers do not exist. All other behaviour is identical.

## Test plan
- SEED=1, BITS=32, golden comparator, start pulse:
  - vector 0 drives A=0x00042021, B=0x04080601 and expects 0.
  - o_done rises at edge 32 with o_pass=1, o_err_cnt=0, o_vec_cnt=16.
- Inverted comparator (i_result = !(A>B)): o_err_cnt=16 and o_pass=0 at done. With capture: o_fail_idx=0, o_fail_A=0x00042021, o_fail_B=0x04080601.
- i_result stuck at 0: o_err_cnt equals the number of vectors with A>B, as computed by the bench model. With capture, o_fail_idx is the first such index.
- Pulse i_start again during CHECK of vector 3: ignored, and o_done still rises at edge 32. Restart from DONE: identical operand sequence and cleared counters.
- Assert i_rst_n=0 during vector 5: all outputs become 0 immediately and the state is IDLE. A subsequent start replays vector 0 = {0x00042021, 0x04080601}.
- BITS=8, SEED=1: vector 0 is A=0x21, B=0x01, expected 1.

Source files
------------

// File: rtl/porownanie_bist_if.sv
// Comparator bus between the BIST driver (master) and the comparator under
// test (slave): two operands out, one combinational result back.
interface porownanie_bist_if #(
  parameter int BITS = 32
);
  logic [BITS-1:0] o_arg_A;
  logic [BITS-1:0] o_arg_B;
  logic            i_result;

  modport master (output o_arg_A, output o_arg_B, input i_result);
  modport slave  (input o_arg_A, input o_arg_B, output i_result);
endinterface

// File: rtl/porownanie_bist.sv
// porownanie_bist: on-chip BIST driver/checker for the comparator.
// An xorshift32 generator produces operand pairs, two steps per vector; each
// vector is driven for one GEN cycle and checked at the end of the following
// CHECK cycle against the contract result = (A > B), unsigned.
// Optional feature macro: PORWN_BIST_CAPTURE_EN adds first-mismatch capture
// ports o_fail_A, o_fail_B and o_fail_idx.
module porownanie_bist #(
  parameter int          BITS      = 32,
  parameter int          N_VECTORS = 16,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  localparam int         CW        = $clog2(N_VECTORS + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  porownanie_bist_if.master    cmp,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [CW-1:0]        o_err_cnt,
  output logic [CW-1:0]        o_vec_cnt
`ifdef PORWN_BIST_CAPTURE_EN
  ,
  output logic [BITS-1:0]      o_fail_A,
  output logic [BITS-1:0]      o_fail_B,
  output logic [CW-1:0]        o_fail_idx
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_CHECK, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     gen_q, gen_d;
  logic [BITS-1:0] arg_a_q, arg_a_d;
  logic [BITS-1:0] arg_b_q, arg_b_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [CW-1:0]   err_cnt_q, err_cnt_d;
  logic [CW-1:0]   vec_cnt_q, vec_cnt_d;
`ifdef PORWN_BIST_CAPTURE_EN
  logic [BITS-1:0] fail_a_q, fail_a_d;
  logic [BITS-1:0] fail_b_q, fail_b_d;
  logic [CW-1:0]   fail_idx_q, fail_idx_d;
  logic            captured_q, captured_d;
`endif

  logic [31:0] s1, s2;
  logic        expect_gt;
  logic        mismatch;
  logic        last_vec;

  // One xorshift32 step.
  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // Next-state logic for the run sequencer, counters and operand registers.
  always_comb begin
    s1        = xs_step(gen_q);
    s2        = xs_step(s1);
    expect_gt = (arg_a_q > arg_b_q);
    mismatch  = (cmp.i_result != expect_gt);
    last_vec  = ((int'(vec_cnt_q) + 1) == N_VECTORS);

    state_d   = state_q;
    gen_d     = gen_q;
    arg_a_d   = arg_a_q;
    arg_b_d   = arg_b_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_cnt_d = err_cnt_q;
    vec_cnt_d = vec_cnt_q;
`ifdef PORWN_BIST_CAPTURE_EN
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    fail_idx_d = fail_idx_q;
    captured_d = captured_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          // Reloading the seed makes every run replay the same vectors.
          state_d   = S_GEN;
          gen_d     = SEED;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_cnt_d = '0;
          vec_cnt_d = '0;
`ifdef PORWN_BIST_CAPTURE_EN
          fail_a_d   = '0;
          fail_b_d   = '0;
          fail_idx_d = '0;
          captured_d = 1'b0;
`endif
        end
      end
      S_GEN: begin
        arg_a_d = s1[BITS-1:0];
        arg_b_d = s2[BITS-1:0];
        gen_d   = s2;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (mismatch) begin
          err_cnt_d = sat_inc(err_cnt_q);
`ifdef PORWN_BIST_CAPTURE_EN
          if (!captured_q) begin
            fail_a_d   = arg_a_q;
            fail_b_d   = arg_b_q;
            fail_idx_d = vec_cnt_q;
            captured_d = 1'b1;
          end
`endif
        end
        vec_cnt_d = vec_cnt_q + CW'(1);
        if (last_vec) begin
          // Pass uses the updated count so a last-vector miss is included.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
        end else begin
          state_d = S_GEN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any run and returns all outputs to 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      gen_q     <= SEED;
      arg_a_q   <= '0;
      arg_b_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
      vec_cnt_q <= '0;
`ifdef PORWN_BIST_CAPTURE_EN
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_idx_q <= '0;
      captured_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gen_q     <= gen_d;
      arg_a_q   <= arg_a_d;
      arg_b_q   <= arg_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_cnt_q <= err_cnt_d;
      vec_cnt_q <= vec_cnt_d;
`ifdef PORWN_BIST_CAPTURE_EN
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      fail_idx_q <= fail_idx_d;
      captured_q <= captured_d;
`endif
    end
  end

  assign cmp.o_arg_A = arg_a_q;
  assign cmp.o_arg_B = arg_b_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_vec_cnt   = vec_cnt_q;
`ifdef PORWN_BIST_CAPTURE_EN
  assign o_fail_A    = fail_a_q;
  assign o_fail_B    = fail_b_q;
  assign o_fail_idx  = fail_idx_q;
`endif

endmodule

// File: tb/tb_porownanie_bist.sv
// Testbench for porownanie_bist: timing-level model plus directed runs with
// golden, inverted and stuck-at-0 comparators, an 8-bit instance alongside.
module tb_porownanie_bist;
  localparam int          BITS = 32;
  localparam int          NV   = 16;
  localparam int          CW   = $clog2(NV + 1);
  localparam logic [31:0] SEED = 32'h0000_0001;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  int   mode;   // 0 golden, 1 inverted, 2 stuck at 0
  int   tests = 0;
  int   fails = 0;

  logic            busy, done, pass;
  logic [CW-1:0]   err_cnt, vec_cnt;
  logic            busy8, done8, pass8;
  logic [CW-1:0]   err_cnt8, vec_cnt8;
`ifdef PORWN_BIST_CAPTURE_EN
  logic [BITS-1:0] fail_a, fail_b;
  logic [CW-1:0]   fail_idx;
  logic [7:0]      fail_a8, fail_b8;
  logic [CW-1:0]   fail_idx8;
`endif

  always #5 clk = ~clk;

  porownanie_bist_if #(.BITS(BITS)) bus ();
  porownanie_bist_if #(.BITS(8))    bus8 ();

  assign bus.i_result  = (mode == 0) ? (bus.o_arg_A > bus.o_arg_B) :
                         (mode == 1) ? !(bus.o_arg_A > bus.o_arg_B) : 1'b0;
  assign bus8.i_result = (bus8.o_arg_A > bus8.o_arg_B);

  porownanie_bist #(.BITS(BITS), .N_VECTORS(NV), .SEED(SEED)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .cmp(bus.master),
    .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_err_cnt(err_cnt), .o_vec_cnt(vec_cnt)
`ifdef PORWN_BIST_CAPTURE_EN
    , .o_fail_A(fail_a), .o_fail_B(fail_b), .o_fail_idx(fail_idx)
`endif
  );

  porownanie_bist #(.BITS(8), .N_VECTORS(NV), .SEED(SEED)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .cmp(bus8.master),
    .o_busy(busy8), .o_done(done8), .o_pass(pass8),
    .o_err_cnt(err_cnt8), .o_vec_cnt(vec_cnt8)
`ifdef PORWN_BIST_CAPTURE_EN
    , .o_fail_A(fail_a8), .o_fail_B(fail_b8), .o_fail_idx(fail_idx8)
`endif
  );

  // Reference operand sequence from the xorshift32 definition.
  logic [31:0] va [NV];
  logic [31:0] vb [NV];

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    return y ^ (y << 5);
  endfunction

  function automatic bit mis(input int md, input int k);
    if (md == 0) return 1'b0;
    if (md == 1) return 1'b1;
    return va[k] > vb[k];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: edges elapsed since the accepted start decide every output.
  bit          m_active;
  int          m_e;
  int          m_mode;
  logic [31:0] m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_e <= 0; m_mode <= 0; m_a <= '0; m_b <= '0;
    end else if (start && (!m_active || m_e >= 2*NV)) begin
      m_active <= 1'b1; m_e <= 0; m_mode <= mode;
    end else if (m_active && m_e < 2*NV) begin
      m_e <= m_e + 1;
      if (m_e % 2 == 0) begin
        m_a <= va[m_e/2];
        m_b <= vb[m_e/2];
      end
    end
  end

  // Per-cycle comparison of the 32-bit DUT against the model.
  always @(negedge clk) begin
    int vc, err, first;
    bit e_busy, e_done;
    vc    = m_active ? ((m_e / 2 < NV) ? m_e / 2 : NV) : 0;
    err   = 0;
    first = -1;
    for (int k = 0; k < vc; k++)
      if (mis(m_mode, k)) begin
        err++;
        if (first < 0) first = k;
      end
    e_busy = m_active && (m_e < 2*NV);
    e_done = m_active && (m_e >= 2*NV);
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("pass", 32'(pass), 32'(e_done && err == 0));
    check("err_cnt", 32'(err_cnt), 32'(err));
    check("vec_cnt", 32'(vec_cnt), 32'(vc));
    check("arg_A", bus.o_arg_A, m_a);
    check("arg_B", bus.o_arg_B, m_b);
`ifdef PORWN_BIST_CAPTURE_EN
    check("fail_idx", 32'(fail_idx), (first < 0) ? 32'd0 : 32'(first));
    check("fail_A", fail_a, (first < 0) ? 32'd0 : va[first]);
    check("fail_B", fail_b, (first < 0) ? 32'd0 : vb[first]);
`endif
  end

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err"}, 32'(err_cnt), 32'd0);
    check({tag, "_vec"}, 32'(vec_cnt), 32'd0);
    check({tag, "_A"}, bus.o_arg_A, 32'd0);
    check({tag, "_B"}, bus.o_arg_B, 32'd0);
`ifdef PORWN_BIST_CAPTURE_EN
    check({tag, "_fidx"}, 32'(fail_idx), 32'd0);
    check({tag, "_fA"}, fail_a, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] s;
    int gt_cnt, gt_first;
    s = SEED;
    for (int k = 0; k < NV; k++) begin
      s = xs(s); va[k] = s;
      s = xs(s); vb[k] = s;
    end
    gt_cnt = 0; gt_first = -1;
    for (int k = 0; k < NV; k++)
      if (va[k] > vb[k]) begin
        gt_cnt++;
        if (gt_first < 0) gt_first = k;
      end

    rst_n = 1'b0; start = 1'b0; mode = 0;
    wait_edges(3);
    check_all_zero("reset");
    check("model_v0_A", va[0], 32'h0004_2021);
    check("model_v0_B", vb[0], 32'h0408_0601);
    @(negedge clk) rst_n = 1'b1;

    // Golden comparator run.
    start_run();
    check("start_busy", 32'(busy), 32'd1);
    wait_edges(1);
    check("v0_A", bus.o_arg_A, 32'h0004_2021);
    check("v0_B", bus.o_arg_B, 32'h0408_0601);
    check("v0_result", 32'(bus.i_result), 32'd0);
    check("b8_v0_A", 32'(bus8.o_arg_A), 32'h21);
    check("b8_v0_B", 32'(bus8.o_arg_B), 32'h01);
    check("b8_v0_result", 32'(bus8.i_result), 32'd1);
    wait_edges(30);
    check("edge31_done", 32'(done), 32'd0);
    wait_edges(1);
    check("edge32_done", 32'(done), 32'd1);
    check("edge32_busy", 32'(busy), 32'd0);
    check("golden_pass", 32'(pass), 32'd1);
    check("golden_err", 32'(err_cnt), 32'd0);
    check("golden_vec", 32'(vec_cnt), 32'd16);
    check("b8_pass", 32'(pass8), 32'd1);

    // Inverted comparator: every vector fails.
    mode = 1;
    start_run();
    wait_edges(32);
    check("inv_err", 32'(err_cnt), 32'd16);
    check("inv_pass", 32'(pass), 32'd0);
    check("inv_done", 32'(done), 32'd1);
`ifdef PORWN_BIST_CAPTURE_EN
    check("inv_fidx", 32'(fail_idx), 32'd0);
    check("inv_fA", fail_a, 32'h0004_2021);
    check("inv_fB", fail_b, 32'h0408_0601);
`endif

    // Result stuck at 0: fails exactly where A > B.
    mode = 2;
    start_run();
    wait_edges(32);
    check("stuck_err", 32'(err_cnt), 32'(gt_cnt));
    check("stuck_pass", 32'(pass), 32'(gt_cnt == 0));
`ifdef PORWN_BIST_CAPTURE_EN
    check("stuck_fidx", 32'(fail_idx), (gt_first < 0) ? 32'd0 : 32'(gt_first));
`endif

    // Start pulse during CHECK of vector 3 is ignored.
    mode = 0;
    start_run();
    wait_edges(7);
    start = 1'b1;
    wait_edges(1);
    start = 1'b0;
    wait_edges(23);
    check("ign_edge31_done", 32'(done), 32'd0);
    wait_edges(1);
    check("ign_edge32_done", 32'(done), 32'd1);
    check("ign_vec", 32'(vec_cnt), 32'd16);

    // Restart from DONE replays the sequence with cleared counters.
    start_run();
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_vec", 32'(vec_cnt), 32'd0);
    check("restart_err", 32'(err_cnt), 32'd0);
    wait_edges(1);
    check("restart_v0_A", bus.o_arg_A, 32'h0004_2021);
    check("restart_v0_B", bus.o_arg_B, 32'h0408_0601);

    // Asynchronous reset during vector 5.
    wait_edges(10);
    check("v5_A", bus.o_arg_A, va[5]);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk) rst_n = 1'b1;
    start_run();
    wait_edges(1);
    check("postrst_v0_A", bus.o_arg_A, 32'h0004_2021);
    check("postrst_v0_B", bus.o_arg_B, 32'h0408_0601);
    wait_edges(31);
    check("postrst_done", 32'(done), 32'd1);
    check("postrst_pass", 32'(pass), 32'd1);

    wait_edges(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
